// File: rtl/calc_pkg.sv
// Shared opcodes and sequencer state for the parameterised calculator.
// Imported by the ALU and the top-level register/sequencer block.
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_ASR = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;
  localparam logic [3:0] OP_ROR = 4'b1011;
  localparam logic [3:0] OP_EQ  = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational single-cycle datapath: arithmetic, logic, shift, compare.
// Opcodes 1110/1111 and MUL fall to the default and yield zero.
module calc_alu
  import calc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  output logic [DATA_W-1:0] r_o,
  output logic              c_o
);

  localparam int S = $clog2(DATA_W);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] dif;
  logic [S-1:0]    sh;
  logic            eq;

  assign sum = {1'b0, x_i} + {1'b0, y_i};
  assign dif = {x_i[DATA_W-1], x_i} - {y_i[DATA_W-1], y_i};
  assign sh  = x_i[S-1:0];
  assign eq  = (x_i == y_i);

  always_comb begin
    r_o = '0;
    c_o = 1'b0;
    case (op_i)
      OP_ADD: {c_o, r_o} = sum;
      OP_SUB: {c_o, r_o} = dif;
      OP_AND: r_o = x_i & y_i;
      OP_OR:  r_o = x_i | y_i;
      OP_NOT: r_o = ~x_i;
      OP_XOR: r_o = x_i ^ y_i;
      OP_NOR: r_o = ~(x_i | y_i);
      OP_SHL: r_o = y_i << sh;
      OP_SHR: r_o = y_i >> sh;
      OP_ASR: r_o = {x_i[DATA_W-1], x_i[DATA_W-1:1]};
      OP_ROL: r_o = {x_i[DATA_W-2:0], x_i[DATA_W-1]};
      OP_ROR: r_o = {x_i[0], x_i[DATA_W-1:1]};
      OP_EQ:  r_o = {{(DATA_W-1){1'b0}}, eq};
      default: begin
        r_o = '0;
        c_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/param_calculator.sv
// Register-file calculator: single-cycle ALU ops plus a
// shift-add multiplier sequencer that stalls intake while running.
module param_calculator
  import calc_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NREG   = 8,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [3:0]        Ctrl,
  input  logic              Sel,
  input  logic [AW-1:0]     RX,
  input  logic [AW-1:0]     RY,
  input  logic [AW-1:0]     RW,
  input  logic              WEN,
  input  logic [DATA_W-1:0] DataIn,
  output logic              Out_valid,
  output logic [DATA_W-1:0] Out_data,
  output logic              Carry,
  output logic              Zero,
  output logic [DATA_W-1:0] busY
);

  localparam int CW = $clog2(DATA_W);

  state_t state_q, state_d;

  logic [DATA_W-1:0]   regs_q [NREG];
  logic [2*DATA_W-1:0] prod_q;
  logic [DATA_W-1:0]   mcand_q;
  logic [CW-1:0]       cnt_q;
  logic [AW-1:0]       rw_q;
  logic                wen_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                carry_q;
  logic                zero_q;

  logic                accept;
  logic                is_mul;
  logic                is_nop;
  logic [DATA_W-1:0]   x_op;
  logic [DATA_W-1:0]   y_op;
  logic [DATA_W-1:0]   alu_r;
  logic                alu_c;
  logic [DATA_W:0]     mul_add;
  logic [2*DATA_W-1:0] prod_nx;
  logic                mul_last;
  logic                done_single;
  logic                done;
  logic [DATA_W-1:0]   res;
  logic                res_c;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;

  assign accept = In_valid & In_ready;
  assign is_mul = (Ctrl == OP_MUL);
  assign is_nop = (Ctrl[3:1] == 3'b111);
  assign x_op   = Sel ? regs_q[RX] : DataIn;
  assign y_op   = regs_q[RY];
  assign busY   = regs_q[RY];

  calc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i (Ctrl),
    .x_i  (x_op),
    .y_i  (y_op),
    .r_o  (alu_r),
    .c_o  (alu_c)
  );

  // Multiplier sits in the low half of prod_q and is shifted out LSB first.
  assign mul_add = {1'b0, prod_q[2*DATA_W-1:DATA_W]}
                 + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_nx = {mul_add, prod_q[DATA_W-1:1]};
  assign mul_last = (state_q == ST_MUL) &&
                    (cnt_q == CW'(DATA_W - 1));

  assign done_single = accept & ~is_mul;
  assign done        = done_single | mul_last;
  assign res   = mul_last ? prod_nx[DATA_W-1:0] : alu_r;
  assign res_c = mul_last ? |prod_nx[2*DATA_W-1:DATA_W] : alu_c;

  assign wr_addr = mul_last ? rw_q : RW;
  assign wr_en   = ((done_single & WEN & ~is_nop) |
                    (mul_last & wen_q)) &&
                   (wr_addr != '0);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && is_mul) state_d = ST_MUL;
      ST_MUL:  if (mul_last)         state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    In_ready = (state_q == ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_addr] <= res;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      rw_q    <= '0;
      wen_q   <= 1'b0;
    end else if (accept && is_mul) begin
      prod_q  <= {{DATA_W{1'b0}}, x_op};
      mcand_q <= y_op;
      cnt_q   <= '0;
      rw_q    <= RW;
      wen_q   <= WEN;
    end else if (state_q == ST_MUL) begin
      prod_q  <= prod_nx;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= done;
      if (done) begin
        out_data_q <= res;
        carry_q    <= res_c;
        zero_q     <= (res == '0);
      end
    end
  end

  assign Out_valid = out_valid_q;
  assign Out_data  = out_data_q;
  assign Carry     = carry_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_param_calculator.sv
// Directed bench for param_calculator (DATA_W=8, NREG=8).
// Expected values are hand-computed constants.
module tb_param_calculator;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       In_valid = 1'b0;
  logic       In_ready;
  logic [3:0] Ctrl = '0;
  logic       Sel = 1'b0;
  logic [2:0] RX = '0;
  logic [2:0] RY = '0;
  logic [2:0] RW = '0;
  logic       WEN = 1'b0;
  logic [7:0] DataIn = '0;
  logic       Out_valid;
  logic [7:0] Out_data;
  logic       Carry;
  logic       Zero;
  logic [7:0] busY;

  int n_cmp = 0;
  int n_err = 0;

  param_calculator #(
    .DATA_W (8),
    .NREG   (8)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .Ctrl      (Ctrl),
    .Sel       (Sel),
    .RX        (RX),
    .RY        (RY),
    .RW        (RW),
    .WEN       (WEN),
    .DataIn    (DataIn),
    .Out_valid (Out_valid),
    .Out_data  (Out_data),
    .Carry     (Carry),
    .Zero      (Zero),
    .busY      (busY)
  );

  always #5 Clk = ~Clk;

  task automatic expect_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic s,
                       input logic [2:0] rx, input logic [2:0] ry,
                       input logic [2:0] rw, input logic w,
                       input logic [7:0] d);
    Ctrl = op; Sel = s; RX = rx; RY = ry; RW = rw;
    WEN = w; DataIn = d; In_valid = 1'b1;
    @(posedge Clk); #1;
    In_valid = 1'b0;
  endtask

  task automatic wr(input logic [2:0] k, input logic [7:0] v);
    issue(4'b0000, 1'b0, 3'd0, 3'd0, k, 1'b1, v);
  endtask

  task automatic peek(input string tag, input logic [2:0] k,
                      input logic [7:0] exp);
    RY = k; #1;
    expect_eq(tag, {24'b0, busY}, {24'b0, exp});
  endtask

  typedef struct {
    logic [3:0] op;
    logic       s;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [2:0] rw;
    logic       w;
    logic [7:0] d;
    logic [7:0] er;
    logic       ec;
  } vec_t;

  // r1=FF, r2=01 when these run
  vec_t vecs [15] = '{
    '{4'b0001, 0, 0, 2, 7, 0, 8'h05, 8'h04, 0},
    '{4'b0001, 0, 0, 2, 7, 0, 8'h00, 8'hFF, 1},
    '{4'b0010, 1, 1, 2, 7, 0, 8'h00, 8'h01, 0},
    '{4'b0011, 0, 0, 2, 7, 0, 8'h80, 8'h81, 0},
    '{4'b0100, 0, 0, 2, 7, 0, 8'h0F, 8'hF0, 0},
    '{4'b0101, 0, 0, 1, 7, 0, 8'hF0, 8'h0F, 0},
    '{4'b0110, 0, 0, 2, 7, 0, 8'hF0, 8'h0E, 0},
    '{4'b0111, 0, 0, 2, 7, 0, 8'h0B, 8'h08, 0},
    '{4'b1000, 0, 0, 1, 7, 0, 8'h04, 8'h0F, 0},
    '{4'b1001, 0, 0, 2, 7, 0, 8'h80, 8'hC0, 0},
    '{4'b1010, 0, 0, 2, 7, 0, 8'h81, 8'h03, 0},
    '{4'b1011, 0, 0, 2, 7, 0, 8'h81, 8'hC0, 0},
    '{4'b1100, 0, 0, 1, 7, 0, 8'hFF, 8'h01, 0},
    '{4'b1100, 0, 0, 1, 7, 0, 8'hFE, 8'h00, 0},
    '{4'b1110, 0, 0, 1, 5, 1, 8'h33, 8'h00, 0}
  };

  task automatic run_mul(input string tag, input logic [2:0] rw,
                         input logic [7:0] er, input logic ec,
                         input logic [7:0] rexp);
    int n;
    int low;
    n = 0;
    low = 0;
    issue(4'b1101, 1'b1, 3'd1, 3'd3, rw, 1'b1, 8'h00);
    while (!Out_valid && n < 20) begin
      if (!In_ready) low++;
      @(posedge Clk); #1;
      n++;
    end
    expect_eq({tag, "_edges"}, n + 1, 9);
    expect_eq({tag, "_stall"}, low, 8);
    expect_eq({tag, "_data"}, {24'b0, Out_data}, {24'b0, er});
    expect_eq({tag, "_carry"}, {31'b0, Carry}, {31'b0, ec});
    expect_eq({tag, "_zero"}, {31'b0, Zero}, {31'b0, er == 8'h00});
    peek({tag, "_reg"}, rw, rexp);
    @(posedge Clk); #1;
    expect_eq({tag, "_vdrop"}, {31'b0, Out_valid}, 0);
  endtask

  initial begin
    int pulses;
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    expect_eq("rst_ovalid", {31'b0, Out_valid}, 0);
    expect_eq("rst_odata", {24'b0, Out_data}, 0);
    expect_eq("rst_carry", {31'b0, Carry}, 0);
    expect_eq("rst_zero", {31'b0, Zero}, 0);
    expect_eq("rst_ready", {31'b0, In_ready}, 1);
    for (int k = 0; k < 8; k++) peek("rst_busy", 3'(k), 8'h00);
    Rst_n = 1'b1;
    #1;
    expect_eq("rel_ready", {31'b0, In_ready}, 1);
    @(posedge Clk); #1;

    // back-to-back ADDs, second reads the first's result
    issue(4'b0000, 1'b0, 3'd0, 3'd0, 3'd1, 1'b1, 8'h0F);
    expect_eq("add1_valid", {31'b0, Out_valid}, 1);
    expect_eq("add1_data", {24'b0, Out_data}, 8'h0F);
    issue(4'b0000, 1'b1, 3'd1, 3'd1, 3'd2, 1'b1, 8'hAA);
    expect_eq("add2_valid", {31'b0, Out_valid}, 1);
    expect_eq("add2_data", {24'b0, Out_data}, 8'h1E);
    peek("add2_r2", 3'd2, 8'h1E);
    @(posedge Clk); #1;
    expect_eq("idle_valid", {31'b0, Out_valid}, 0);

    wr(3'd1, 8'hFF);
    wr(3'd2, 8'h01);
    issue(4'b0000, 1'b1, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00);
    expect_eq("ovf_data", {24'b0, Out_data}, 8'h00);
    expect_eq("ovf_carry", {31'b0, Carry}, 1);
    expect_eq("ovf_zero", {31'b0, Zero}, 1);

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].op, vecs[i].s, vecs[i].rx, vecs[i].ry,
            vecs[i].rw, vecs[i].w, vecs[i].d);
      expect_eq($sformatf("op%0d_valid", i), {31'b0, Out_valid}, 1);
      expect_eq($sformatf("op%0d_data", i), {24'b0, Out_data},
                {24'b0, vecs[i].er});
      expect_eq($sformatf("op%0d_carry", i), {31'b0, Carry},
                {31'b0, vecs[i].ec});
      expect_eq($sformatf("op%0d_zero", i), {31'b0, Zero},
                {31'b0, vecs[i].er == 8'h00});
    end
    peek("nop_nowrite", 3'd5, 8'h00);

    wr(3'd1, 8'h0F);
    wr(3'd3, 8'h11);
    run_mul("mul_ff", 3'd4, 8'hFF, 1'b0, 8'hFF);

    wr(3'd1, 8'h10);
    wr(3'd3, 8'h10);
    run_mul("mul_ovf", 3'd4, 8'h00, 1'b1, 8'h00);
    wr(3'd6, 8'h5A);
    run_mul("mul_r0", 3'd0, 8'h00, 1'b1, 8'h00);
    peek("mul_r0_r6", 3'd6, 8'h5A);

    // abort a multiply with reset on its 4th cycle
    wr(3'd6, 8'h00);
    wr(3'd1, 8'h03);
    wr(3'd3, 8'h05);
    issue(4'b1101, 1'b1, 3'd1, 3'd3, 3'd6, 1'b1, 8'h00);
    pulses = 0;
    repeat (3) begin
      if (Out_valid) pulses++;
      @(posedge Clk); #1;
    end
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    expect_eq("abort_ready", {31'b0, In_ready}, 1);
    repeat (12) begin
      if (Out_valid) pulses++;
      @(posedge Clk); #1;
    end
    expect_eq("abort_pulses", pulses, 0);
    peek("abort_r6", 3'd6, 8'h00);
    expect_eq("abort_odata", {24'b0, Out_data}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
